// File: rtl/video_src_pkg.sv
// Shared types for the video stream source.
package video_src_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    // Test pattern selector, encoded as on cfg_pattern.
    typedef enum logic [1:0] {
        PAT_XRAMP = 2'd0,
        PAT_YRAMP = 2'd1,
        PAT_DELTA = 2'd2,
        PAT_CONST = 2'd3
    } pattern_t;

endpackage

// File: rtl/video_src_pix.sv
// Registered pattern generator: maps (x, y, latched config) to a pixel.
module video_src_pix
    import video_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  x,
    input  logic [CNT_WIDTH-1:0]  y,
    input  logic [CNT_WIDTH-1:0]  w,
    input  logic [CNT_WIDTH-1:0]  h,
    input  pattern_t              pattern,
    input  logic [DATA_WIDTH-1:0] value,
    output logic [DATA_WIDTH-1:0] pix
);

    logic [DATA_WIDTH-1:0] pix_c;

    // Pattern select for the pixel at the current position.
    always_comb begin
        pix_c = '0;
        case (pattern)
            PAT_XRAMP: pix_c = DATA_WIDTH'(x);
            PAT_YRAMP: pix_c = DATA_WIDTH'(y);
            PAT_DELTA: pix_c = ((x == (w >> 1)) && (y == (h >> 1))) ? '1 : '0;
            PAT_CONST: pix_c = value;
            default:   pix_c = '0;
        endcase
    end

    // Capture only on DE cycles so the pixel holds between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix <= '0;
        end else if (load) begin
            pix <= pix_c;
        end
    end

endmodule

// File: rtl/video_src_gen.sv
// Video stream source: frame sequencer, counters, config shadows, registered outputs.
module video_src_gen
    import video_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 12,
    parameter int unsigned GAP_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  cfg_w,
    input  logic [CNT_WIDTH-1:0]  cfg_h,
    input  logic [GAP_WIDTH-1:0]  cfg_de_gap,
    input  logic [CNT_WIDTH-1:0]  cfg_hblank,
    input  logic [CNT_WIDTH-1:0]  cfg_vblank,
    input  logic [1:0]            cfg_pattern,
    input  logic [DATA_WIDTH-1:0] cfg_value,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    state_t state, state_nx;

    logic [CNT_WIDTH-1:0]  x_q, x_nx;
    logic [CNT_WIDTH-1:0]  y_q, y_nx;
    logic [CNT_WIDTH-1:0]  blank_q, blank_nx;
    logic [GAP_WIDTH-1:0]  gap_q, gap_nx;

    // Shadow config; blank lengths are stored already clamped to >= 1.
    logic [CNT_WIDTH-1:0]  w_q, w_nx;
    logic [CNT_WIDTH-1:0]  h_q, h_nx;
    logic [GAP_WIDTH-1:0]  gap_cfg_q, gap_cfg_nx;
    logic [CNT_WIDTH-1:0]  hblank_q, hblank_nx;
    logic [CNT_WIDTH-1:0]  vblank_q, vblank_nx;
    pattern_t              pat_q, pat_nx;
    logic [DATA_WIDTH-1:0] value_q, value_nx;

    logic start_c;
    logic latch_c;
    logic de_c;
    logic hs_c;
    logic vs_c;
    logic busy_c;
    logic done_c;

    assign start_c = en && (cfg_w != '0) && (cfg_h != '0);

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nx   = state;
        x_nx       = x_q;
        y_nx       = y_q;
        blank_nx   = blank_q;
        gap_nx     = gap_q;
        w_nx       = w_q;
        h_nx       = h_q;
        gap_cfg_nx = gap_cfg_q;
        hblank_nx  = hblank_q;
        vblank_nx  = vblank_q;
        pat_nx     = pat_q;
        value_nx   = value_q;
        latch_c    = 1'b0;
        de_c       = 1'b0;
        hs_c       = 1'b1;
        vs_c       = 1'b1;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    state_nx = ST_ACTIVE;
                    latch_c  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                hs_c   = 1'b0;
                vs_c   = 1'b0;
                busy_c = 1'b1;
                if (gap_q != gap_cfg_q) begin
                    gap_nx = gap_q + GAP_WIDTH'(1);
                end else begin
                    de_c   = 1'b1;
                    gap_nx = '0;
                    if (x_q == w_q - CNT_WIDTH'(1)) begin
                        x_nx     = '0;
                        blank_nx = '0;
                        state_nx = (y_q == h_q - CNT_WIDTH'(1)) ? ST_VBLANK : ST_HBLANK;
                    end else begin
                        x_nx = x_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_HBLANK: begin
                vs_c   = 1'b0;
                busy_c = 1'b1;
                if (blank_q == hblank_q - CNT_WIDTH'(1)) begin
                    blank_nx = '0;
                    y_nx     = y_q + CNT_WIDTH'(1);
                    state_nx = ST_ACTIVE;
                end else begin
                    blank_nx = blank_q + CNT_WIDTH'(1);
                end
            end
            ST_VBLANK: begin
                busy_c = 1'b1;
                if (blank_q == vblank_q - CNT_WIDTH'(1)) begin
                    done_c   = 1'b1;
                    blank_nx = '0;
                    y_nx     = '0;
                    if (start_c) begin
                        state_nx = ST_ACTIVE;
                        latch_c  = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    blank_nx = blank_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Frame start: snapshot config and rewind the raster position.
        if (latch_c) begin
            x_nx       = '0;
            y_nx       = '0;
            gap_nx     = '0;
            blank_nx   = '0;
            w_nx       = cfg_w;
            h_nx       = cfg_h;
            gap_cfg_nx = cfg_de_gap;
            hblank_nx  = (cfg_hblank == '0) ? CNT_WIDTH'(1) : cfg_hblank;
            vblank_nx  = (cfg_vblank == '0) ? CNT_WIDTH'(1) : cfg_vblank;
            pat_nx     = pattern_t'(cfg_pattern);
            value_nx   = cfg_value;
        end
    end

    // State, counters and config shadows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            blank_q   <= '0;
            gap_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            gap_cfg_q <= '0;
            hblank_q  <= CNT_WIDTH'(1);
            vblank_q  <= CNT_WIDTH'(1);
            pat_q     <= PAT_XRAMP;
            value_q   <= '0;
        end else begin
            state     <= state_nx;
            x_q       <= x_nx;
            y_q       <= y_nx;
            blank_q   <= blank_nx;
            gap_q     <= gap_nx;
            w_q       <= w_nx;
            h_q       <= h_nx;
            gap_cfg_q <= gap_cfg_nx;
            hblank_q  <= hblank_nx;
            vblank_q  <= vblank_nx;
            pat_q     <= pat_nx;
            value_q   <= value_nx;
        end
    end

    // Sync/strobe stage, aligned with the registered pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_o         <= 1'b0;
            hs_o         <= 1'b1;
            vs_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            de_o         <= de_c;
            hs_o         <= hs_c;
            vs_o         <= vs_c;
            busy_o       <= busy_c;
            frame_done_o <= done_c;
        end
    end

    video_src_pix #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pix (
        .clk     (clk),
        .rst     (rst),
        .load    (de_c),
        .x       (x_q),
        .y       (y_q),
        .w       (w_q),
        .h       (h_q),
        .pattern (pat_q),
        .value   (value_q),
        .pix     (do_o)
    );

endmodule

// File: tb/tb_video_src_gen.sv
// Self-checking bench for video_src_gen: frame-level model vs. per-cycle output stream.
module tb_video_src_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] cfg_w;
    logic [11:0] cfg_h;
    logic [3:0]  cfg_de_gap;
    logic [11:0] cfg_hblank;
    logic [11:0] cfg_vblank;
    logic [1:0]  cfg_pattern;
    logic [7:0]  cfg_value;
    logic [7:0]  do_o;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;
    logic        busy_o;
    logic        frame_done_o;

    video_src_gen dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_w        (cfg_w),
        .cfg_h        (cfg_h),
        .cfg_de_gap   (cfg_de_gap),
        .cfg_hblank   (cfg_hblank),
        .cfg_vblank   (cfg_vblank),
        .cfg_pattern  (cfg_pattern),
        .cfg_value    (cfg_value),
        .do_o         (do_o),
        .de_o         (de_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected output cycle; field order matches the observed vector.
    typedef struct packed {
        logic [7:0] d;
        logic       de;
        logic       hs;
        logic       vs;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         rd;
    logic [7:0] build_do;
    int         total;
    int         bad;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic push_cyc(input logic [7:0] d, input logic de, input logic hs, input logic vs, input logic done);
        exp_t e;
        e.d    = d;
        e.de   = de;
        e.hs   = hs;
        e.vs   = vs;
        e.busy = 1'b1;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Expected cycles of one whole frame, straight from the raster rules.
    task automatic push_frame(input int w, input int h, input int gap, input int hb, input int vb,
                              input int pat, input logic [7:0] val,
                              output int len, output int nde, output int nones);
        int hb_e;
        int vb_e;
        logic [7:0] p;
        hb_e  = (hb == 0) ? 1 : hb;
        vb_e  = (vb == 0) ? 1 : vb;
        len   = 0;
        nde   = 0;
        nones = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                for (int g = 0; g < gap; g++) begin
                    push_cyc(build_do, 1'b0, 1'b0, 1'b0, 1'b0);
                    len++;
                end
                case (pat)
                    0:       p = 8'(x);
                    1:       p = 8'(y);
                    2:       p = (x == w / 2 && y == h / 2) ? 8'hFF : 8'h00;
                    default: p = val;
                endcase
                build_do = p;
                push_cyc(p, 1'b1, 1'b0, 1'b0, 1'b0);
                len++;
                nde++;
                if (p == 8'hFF) nones++;
            end
            if (y < h - 1) begin
                for (int i = 0; i < hb_e; i++) begin
                    push_cyc(build_do, 1'b0, 1'b1, 1'b0, 1'b0);
                    len++;
                end
            end
        end
        for (int i = 0; i < vb_e; i++) begin
            push_cyc(build_do, 1'b0, 1'b1, 1'b1, i == vb_e - 1);
            len++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cfg(input int w, input int h, input int gap, input int hb, input int vb,
                           input int pat, input logic [7:0] val);
        cfg_w       = 12'(w);
        cfg_h       = 12'(h);
        cfg_de_gap  = 4'(gap);
        cfg_hblank  = 12'(hb);
        cfg_vblank  = 12'(vb);
        cfg_pattern = 2'(pat);
        cfg_value   = val;
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 20; i++) begin
            if (busy_o) break;
            @(posedge clk);
            #1;
        end
        chk(name, 0, 32'(busy_o), 32'd1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (frame_done_o) break;
        end
        chk(name, 0, 32'(frame_done_o), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 5000; i++) begin
            if (rd == exp_q.size()) break;
            @(negedge clk);
            #1;
        end
        chk(name, 0, 32'(rd), 32'(exp_q.size()));
    endtask

    initial begin
        int   len;
        int   nde;
        int   nones;
        int   len2;
        logic started;
        logic [7:0] last_do;
        exp_t e;

        total    = 0;
        bad      = 0;
        rd       = 0;
        build_do = 8'h00;
        rst      = 1'b0;
        en       = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 8'h00);

        fork
            begin : driver
                repeat (3) step();
                rst = 1'b1;
                repeat (3) step();
                chk("reset_idle", 0, 32'({de_o, hs_o, vs_o, busy_o, frame_done_o, do_o}), 32'h0C00);

                // 1: gapped x-ramp, two lines.
                set_cfg(4, 2, 3, 5, 10, 0, 8'h00);
                push_frame(4, 2, 3, 5, 10, 0, 8'h00, len, nde, nones);
                chk("t1_model_len", 0, 32'(len), 32'd47);
                chk("t1_model_de", 0, 32'(nde), 32'd8);
                en = 1'b1;
                step();
                wait_busy("t1_busy");
                en = 1'b0;
                wait_drain("t1_drain");
                repeat (4) step();

                // 2: continuous DE delta pulse, zero blanks clamp to one.
                set_cfg(25, 25, 0, 0, 0, 2, 8'h00);
                push_frame(25, 25, 0, 0, 0, 2, 8'h00, len, nde, nones);
                chk("t2_model_len", 0, 32'(len), 32'd650);
                chk("t2_model_de", 0, 32'(nde), 32'd625);
                chk("t2_model_ones", 0, 32'(nones), 32'd1);
                en = 1'b1;
                step();
                wait_busy("t2_busy");
                en = 1'b0;
                wait_drain("t2_drain");
                repeat (4) step();

                // 3: two back-to-back y-ramp frames.
                set_cfg(3, 4, 1, 2, 3, 1, 8'h00);
                push_frame(3, 4, 1, 2, 3, 1, 8'h00, len, nde, nones);
                push_frame(3, 4, 1, 2, 3, 1, 8'h00, len2, nde, nones);
                chk("t3_model_len", 0, 32'(len + len2), 32'd66);
                en = 1'b1;
                step();
                wait_busy("t3_busy");
                wait_done("t3_done1");
                en = 1'b0;
                wait_drain("t3_drain");
                repeat (4) step();

                // 4: en dropped on line 0 still yields the full frame.
                set_cfg(8, 4, 0, 3, 4, 0, 8'h00);
                push_frame(8, 4, 0, 3, 4, 0, 8'h00, len, nde, nones);
                chk("t4_model_de", 0, 32'(nde), 32'd32);
                en = 1'b1;
                step();
                wait_busy("t4_busy");
                step();
                en = 1'b0;
                wait_drain("t4_drain");
                repeat (3) step();
                chk("t4_idle", 0, 32'({hs_o, vs_o, busy_o}), 32'b110);

                // 5: async reset mid-line, then restart from x=0, y=0.
                set_cfg(5, 3, 1, 2, 2, 0, 8'h00);
                push_frame(5, 3, 1, 2, 2, 0, 8'h00, len, nde, nones);
                en = 1'b1;
                step();
                wait_busy("t5_busy");
                repeat (4) step();
                rst = 1'b0;
                #1;
                chk("t5_rst_idle", 0, 32'({de_o, hs_o, vs_o, busy_o, frame_done_o, do_o}), 32'h0C00);
                step();
                step();
                rst = 1'b1;
                build_do = 8'h00;
                push_frame(5, 3, 1, 2, 2, 0, 8'h00, len, nde, nones);
                step();
                wait_busy("t5_busy2");
                en = 1'b0;
                wait_drain("t5_drain");
                repeat (4) step();

                // 6: width change mid-frame lands on the next frame; zero width never starts.
                set_cfg(4, 2, 0, 1, 2, 3, 8'h5A);
                push_frame(4, 2, 0, 1, 2, 3, 8'h5A, len, nde, nones);
                push_frame(6, 2, 0, 1, 2, 3, 8'h5A, len2, nde, nones);
                chk("t6_model_len", 0, 32'(len + len2), 32'd26);
                en = 1'b1;
                step();
                wait_busy("t6_busy");
                step();
                cfg_w = 12'd6;
                wait_done("t6_done1");
                en = 1'b0;
                wait_drain("t6_drain");
                repeat (4) step();
                cfg_w = 12'd0;
                en = 1'b1;
                repeat (20) step();
                chk("t6_zero_w_busy", 0, 32'(busy_o), 32'd0);
                en = 1'b0;
                repeat (3) step();
            end
            begin : compare
                started = 1'b0;
                last_do = 8'h00;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        rd      = exp_q.size();
                        started = 1'b0;
                        last_do = 8'h00;
                        chk("rst_out", rd, 32'({do_o, de_o, hs_o, vs_o, busy_o, frame_done_o}), 32'({8'h00, 5'b01100}));
                    end else begin
                        if (!started && busy_o && rd < exp_q.size()) started = 1'b1;
                        if (started) begin
                            e = exp_q[rd];
                            chk("stream", rd, 32'({do_o, de_o, hs_o, vs_o, busy_o, frame_done_o}), 32'(e));
                            last_do = e.d;
                            rd++;
                            if (rd == exp_q.size()) started = 1'b0;
                        end else begin
                            chk("idle_out", rd, 32'({do_o, de_o, hs_o, vs_o, busy_o, frame_done_o}), 32'({last_do, 5'b01100}));
                        end
                    end
                end
            end
        join_any

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
